// File: rtl/store_buffer_if.sv
// Store-path, load-path and data-memory port bundle for store_buffer.
// The slave modport is the buffer's view; master is the core/memory side.
interface store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    logic                         st_valid;
    logic [AW-1:0]                st_addr;
    logic [DW-1:0]                st_data;
    logic                         st_ready;
    logic                         ld_req;
    logic [AW-1:0]                ld_addr;
    logic [DW-1:0]                ld_data;
    logic                         ld_ready;
    logic [AW-1:0]                dm_address;
    logic [DW-1:0]                dm_wd;
    logic                         dm_we;
    logic [DW-1:0]                dm_rd;
    logic                         empty;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport slave (
        input  st_valid, st_addr, st_data, ld_req, ld_addr, dm_rd,
        output st_ready, ld_data, ld_ready, dm_address, dm_wd, dm_we, empty, count
    );

    modport master (
        output st_valid, st_addr, st_data, ld_req, ld_addr, dm_rd,
        input  st_ready, ld_data, ld_ready, dm_address, dm_wd, dm_we, empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core store path and the single-port data memory.
// Define STORE_BUF_FWD_EN to forward load hits from pending entries; otherwise hits force a drain.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk_i,
    input  logic          reset_i,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          enq;
    logic          drain;
    logic          hit;
    logic          not_empty;

    assign not_empty    = (count_q != '0);
    assign bus.st_ready = (count_q != CW'(DEPTH));
    assign bus.empty    = !not_empty;
    assign bus.count    = count_q;
    assign enq          = bus.st_valid && bus.st_ready;

`ifdef STORE_BUF_FWD_EN
    logic [DW-1:0] hit_data;

    // Youngest-first search: walk back from tail-1 over the occupied slots only.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && (CW'(i) < count_q) &&
                (addr_q[tail_q - PW'(i + 1)] == bus.ld_addr)) begin
                hit      = 1'b1;
                hit_data = data_q[tail_q - PW'(i + 1)];
            end
        end
    end

    assign drain        = !bus.ld_req && not_empty;
    assign bus.ld_ready = bus.ld_req;
    assign bus.ld_data  = hit ? hit_data : bus.dm_rd;
`else
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (addr_q[tail_q - PW'(i + 1)] == bus.ld_addr)) begin
                hit = 1'b1;
            end
        end
    end

    // A hit stalls the load and steals the port so older stores reach memory first.
    assign drain        = not_empty && (!bus.ld_req || hit);
    assign bus.ld_ready = bus.ld_req && !hit;
    assign bus.ld_data  = hit ? '0 : bus.dm_rd;
`endif

    always_comb begin
        bus.dm_we      = 1'b0;
        bus.dm_address = '0;
        bus.dm_wd      = '0;
        if (drain) begin
            bus.dm_we      = 1'b1;
            bus.dm_address = addr_q[head_q];
            bus.dm_wd      = data_q[head_q];
        end else if (bus.ld_req) begin
            bus.dm_address = bus.ld_addr;
        end
    end

    always_comb begin
        head_d  = head_q + PW'(drain);
        tail_d  = tail_q + PW'(enq);
        count_d = count_q + CW'(enq) - CW'(drain);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; count_q alone decides which slots are valid.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            addr_q[tail_q] <= bus.st_addr;
            data_q[tail_q] <= bus.st_data;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue model predicts every memory write, load result and status.
// Honours STORE_BUF_FWD_EN the same way the design does.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] dm_mem  [2**AW] = '{12: 32'hCAFE_0001, default: '0};
    logic [DW-1:0] ref_mem [2**AW] = '{12: 32'hCAFE_0001, default: '0};

    assign bus.dm_rd = dm_mem[bus.dm_address];

    always @(posedge clk) begin
        if (bus.dm_we) dm_mem[bus.dm_address] <= bus.dm_wd;
    end

    entry_t sb[$];
    int     vectors = 0;
    int     errors  = 0;

    task automatic drive(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                         input logic lr, input logic [AW-1:0] la);
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.ld_req   = lr;
        bus.ld_addr  = la;
    endtask

    // Compare the current cycle against the model, advance the model, wait for the next negedge.
    task automatic cycle();
        logic          exp_ready, exp_hit, exp_drain, exp_ldy;
        logic [DW-1:0] exp_ld, fwd;
        int            n;
        #2;
        n         = sb.size();
        exp_ready = (n != DEPTH);
        exp_hit   = 1'b0;
        fwd       = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!exp_hit && sb[i].addr == bus.ld_addr) begin
                exp_hit = 1'b1;
                fwd     = sb[i].data;
            end
        end
`ifdef STORE_BUF_FWD_EN
        exp_drain = !bus.ld_req && (n > 0);
        exp_ldy   = bus.ld_req;
        exp_ld    = exp_hit ? fwd : ref_mem[bus.ld_addr];
`else
        exp_drain = (n > 0) && (!bus.ld_req || exp_hit);
        exp_ldy   = bus.ld_req && !exp_hit;
        exp_ld    = exp_hit ? '0 : ref_mem[bus.ld_addr];
`endif
        vectors++;
        if ({bus.st_ready, bus.empty, bus.count} !== {exp_ready, (n == 0), CW'(n)}) begin
            errors++;
            $display("FAIL status t=%0t got rdy/empty/count=%b/%b/%0d exp=%b/%b/%0d", $time,
                     bus.st_ready, bus.empty, bus.count, exp_ready, (n == 0), n);
        end
        vectors++;
        if (exp_drain) begin
            if ({bus.dm_we, bus.dm_address, bus.dm_wd} !== {1'b1, sb[0].addr, sb[0].data}) begin
                errors++;
                $display("FAIL drain_write t=%0t got we=%b a=%0d d=%h exp we=1 a=%0d d=%h", $time,
                         bus.dm_we, bus.dm_address, bus.dm_wd, sb[0].addr, sb[0].data);
            end
        end else if (bus.ld_req) begin
            if ({bus.dm_we, bus.dm_address} !== {1'b0, bus.ld_addr}) begin
                errors++;
                $display("FAIL load_port t=%0t got we=%b a=%0d exp we=0 a=%0d", $time,
                         bus.dm_we, bus.dm_address, bus.ld_addr);
            end
        end else if ({bus.dm_we, bus.dm_address, bus.dm_wd} !== '0) begin
            errors++;
            $display("FAIL idle_port t=%0t got we=%b a=%0d d=%h exp all zero", $time,
                     bus.dm_we, bus.dm_address, bus.dm_wd);
        end
        if (bus.ld_req) begin
            vectors++;
            if ({bus.ld_ready, bus.ld_data} !== {exp_ldy, exp_ld}) begin
                errors++;
                $display("FAIL load_result t=%0t got rdy=%b d=%h exp rdy=%b d=%h", $time,
                         bus.ld_ready, bus.ld_data, exp_ldy, exp_ld);
            end
        end
        if (exp_drain) begin
            ref_mem[sb[0].addr] = sb[0].data;
            void'(sb.pop_front());
        end
        if (bus.st_valid && exp_ready && !reset) sb.push_back('{addr: bus.st_addr, data: bus.st_data});
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0);
        #1;
        vectors++;
        if ({bus.count, bus.empty, bus.st_ready, bus.dm_we} !== {CW'(0), 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got count=%0d empty=%b rdy=%b we=%b exp 0/1/1/0",
                     bus.count, bus.empty, bus.st_ready, bus.dm_we);
        end
        drive(0, 0, 0, 1, 5);
        #1;
        vectors++;
        if (bus.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ld_ready got %b exp 1", bus.ld_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_single_store();
        drive(1, 3, 32'hDEAD_BEEF, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0);
        #1;
        vectors++;
        if ({bus.dm_we, bus.dm_address, bus.dm_wd} !== {1'b1, 5'd3, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL single_store got we=%b a=%0d d=%h exp 1/3/deadbeef",
                     bus.dm_we, bus.dm_address, bus.dm_wd);
        end
        cycle();
        vectors++;
        if ({bus.empty, dm_mem[3]} !== {1'b1, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL single_store_mem got empty=%b dm3=%h exp 1/deadbeef", bus.empty, dm_mem[3]);
        end
    endtask

    task automatic test_full();
        for (int a = 1; a <= 5; a++) begin
            drive(1, AW'(a), DW'(32'h200 + a), 1, 9);
            if (a == 5) begin
                #1;
                vectors++;
                if ({bus.st_ready, bus.count} !== {1'b0, CW'(4)}) begin
                    errors++;
                    $display("FAIL full got rdy=%b count=%0d exp 0/4", bus.st_ready, bus.count);
                end
            end
            cycle();
        end
        drive(0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            #1;
            vectors++;
            if ({bus.dm_we, bus.dm_address} !== {1'b1, AW'(k)}) begin
                errors++;
                $display("FAIL full_drain got we=%b a=%0d exp 1/%0d", bus.dm_we, bus.dm_address, k);
            end
            cycle();
        end
        #1;
        vectors++;
        if ({bus.dm_we, dm_mem[5]} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL full_dropped got we=%b dm5=%h exp 0/0", bus.dm_we, dm_mem[5]);
        end
        cycle();
        drive(1, 5, 32'h205, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0);
        cycle();
    endtask

    task automatic test_forward();
        drive(1, 7, 32'h11, 1, 9);
        cycle();
        drive(1, 7, 32'h22, 1, 9);
        cycle();
        drive(0, 0, 0, 1, 7);
`ifdef STORE_BUF_FWD_EN
        #1;
        vectors++;
        if ({bus.ld_ready, bus.ld_data, bus.dm_we} !== {1'b1, 32'h22, 1'b0}) begin
            errors++;
            $display("FAIL forward got rdy=%b d=%h we=%b exp 1/22/0", bus.ld_ready, bus.ld_data, bus.dm_we);
        end
        cycle();
`else
        for (int k = 0; k < 2; k++) begin
            #1;
            vectors++;
            if ({bus.ld_ready, bus.dm_we, bus.dm_wd} !== {1'b0, 1'b1, (k == 0) ? 32'h11 : 32'h22}) begin
                errors++;
                $display("FAIL forced_drain%0d got rdy=%b we=%b d=%h", k, bus.ld_ready, bus.dm_we, bus.dm_wd);
            end
            cycle();
        end
        #1;
        vectors++;
        if ({bus.ld_ready, bus.ld_data} !== {1'b1, 32'h22}) begin
            errors++;
            $display("FAIL forced_reload got rdy=%b d=%h exp 1/22", bus.ld_ready, bus.ld_data);
        end
        cycle();
`endif
        drive(0, 0, 0, 0, 0);
        repeat (3) cycle();
    endtask

    task automatic test_load_miss();
        drive(1, 20, 32'hA0, 1, 9);
        cycle();
        drive(1, 21, 32'hA1, 1, 9);
        cycle();
        drive(0, 0, 0, 1, 12);
        #1;
        vectors++;
        if ({bus.ld_ready, bus.ld_data, bus.count} !== {1'b1, 32'hCAFE_0001, CW'(2)}) begin
            errors++;
            $display("FAIL load_miss got rdy=%b d=%h count=%0d exp 1/cafe0001/2",
                     bus.ld_ready, bus.ld_data, bus.count);
        end
        cycle();
        vectors++;
        if (bus.count !== CW'(2)) begin
            errors++;
            $display("FAIL load_miss_count got %0d exp 2", bus.count);
        end
        drive(0, 0, 0, 0, 0);
        repeat (3) cycle();
    endtask

    task automatic test_reset_mid();
        for (int a = 28; a <= 30; a++) begin
            drive(1, AW'(a), DW'(32'hBAD0 + a), 1, 9);
            cycle();
        end
        drive(0, 0, 0, 0, 0);
        #1;
        reset = 1'b1;
        sb.delete();
        #1;
        vectors++;
        if ({bus.count, bus.dm_we, bus.empty} !== {CW'(0), 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid got count=%0d we=%b empty=%b exp 0/0/1", bus.count, bus.dm_we, bus.empty);
        end
        cycle();
        reset = 1'b0;
        repeat (3) cycle();
        vectors++;
        if ({bus.st_ready, dm_mem[28], dm_mem[29], dm_mem[30]} !== {1'b1, 96'h0}) begin
            errors++;
            $display("FAIL reset_discard got rdy=%b dm28..30=%h/%h/%h exp 1/0/0/0",
                     bus.st_ready, dm_mem[28], dm_mem[29], dm_mem[30]);
        end
    endtask

    task automatic test_wrap();
        int   i      = 0;
        int   budget = 0;
        logic accepted;
        while (i < 10 && budget < 100) begin
            drive(1, AW'(i), DW'(32'h100 + i), logic'(budget % 2), 31);
            accepted = (sb.size() != DEPTH);
            cycle();
            if (accepted) i++;
            budget++;
        end
        vectors++;
        if (i != 10) begin
            errors++;
            $display("FAIL wrap_budget got %0d stores accepted exp 10", i);
        end
        drive(0, 0, 0, 0, 0);
        repeat (DEPTH + 1) cycle();
        for (int k = 0; k < 10; k++) begin
            vectors++;
            if (dm_mem[k] !== DW'(32'h100 + k)) begin
                errors++;
                $display("FAIL wrap_mem[%0d] got %h exp %h", k, dm_mem[k], 32'h100 + k);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_store();
        test_full();
        test_forward();
        test_load_miss();
        test_reset_mid();
        test_wrap();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d pending writes exp 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
